// File: rtl/io_input_conditioner.sv
// Per-channel pad synchroniser, debouncer and edge/toggle generator for switch/button inputs.
// Optional toggle flops are built only when IO_COND_TOGGLE_EN is defined.
module io_input_conditioner #(
  parameter int unsigned             WIDTH           = 2,
  parameter int unsigned             DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0]        RESET_LEVEL     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] toggle_out
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] accept_c;

  // A channel accepts its new level on the cycle the count completes
  always_comb begin
    accept_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      accept_c[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // Synchroniser, qualification counters, stable level and edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= RESET_LEVEL;
      sync2      <= RESET_LEVEL;
      stable     <= RESET_LEVEL;
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1      <= raw_in;
      sync2      <= sync1;
      rise_pulse <= accept_c & sync2;
      fall_pulse <= accept_c & ~sync2;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept_c[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign level_out = stable;

`ifdef IO_COND_TOGGLE_EN
  logic [WIDTH-1:0] toggle;

  // Flip on the same edge that raises rise_pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle <= '0;
    end else begin
      toggle <= toggle ^ (accept_c & sync2);
    end
  end

  assign toggle_out = toggle;
`else
  assign toggle_out = '0;
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed scoreboard bench for io_input_conditioner (WIDTH=2, DEBOUNCE_CYCLES=4).
module tb_io_input_conditioner;

  localparam int unsigned W = 2;
  localparam int unsigned N = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] level_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic [W-1:0] toggle_out;

  io_input_conditioner #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(N),
    .RESET_LEVEL    (2'b00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (raw_in),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .toggle_out(toggle_out)
  );

  always #5 clk = ~clk;

  // cyc == k between rising edge k and rising edge k+1
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           at;
    string        tag;
    logic [W-1:0] lvl;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] tog;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [W-1:0] tg(input logic [W-1:0] t);
`ifdef IO_COND_TOGGLE_EN
    return t;
`else
    return '0;
`endif
  endfunction

  task automatic push(input int at, input string tag, input logic [W-1:0] l,
                      input logic [W-1:0] r, input logic [W-1:0] f, input logic [W-1:0] t);
    exp_t e;
    e.at = at; e.tag = tag; e.lvl = l; e.rise = r; e.fall = f; e.tog = tg(t);
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pop every expectation due this cycle and compare
  always @(negedge clk) begin
    if (rst_n) begin
      cmp("no_dual_pulse", rise_pulse & fall_pulse, '0);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at == cyc) begin
          cmp($sformatf("%s@%0d_lvl",  sb[i].tag, cyc), level_out,  sb[i].lvl);
          cmp($sformatf("%s@%0d_rise", sb[i].tag, cyc), rise_pulse, sb[i].rise);
          cmp($sformatf("%s@%0d_fall", sb[i].tag, cyc), fall_pulse, sb[i].fall);
          cmp($sformatf("%s@%0d_tog",  sb[i].tag, cyc), toggle_out, sb[i].tog);
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    int c;
    int s;
    int r;

    // Reset state
    #1;
    cmp("reset_lvl",  level_out,  '0);
    cmp("reset_rise", rise_pulse, '0);
    cmp("reset_fall", fall_pulse, '0);
    cmp("reset_tog",  toggle_out, '0);
    wait_n(3);
    rst_n = 1'b1;
    c = cyc;
    push(c + 3, "idle", 2'b00, 2'b00, 2'b00, 2'b00);
    wait_n(5);

    // Clean rise on channel 0
    c = cyc;
    raw_in[0] = 1'b1;
    push(c + 5, "rise_early", 2'b00, 2'b00, 2'b00, 2'b00);
    push(c + 6, "rise_acc",   2'b01, 2'b01, 2'b00, 2'b01);
    push(c + 7, "rise_end",   2'b01, 2'b00, 2'b00, 2'b01);
    wait_n(10);

    // Three-cycle glitch on channel 1 is rejected
    c = cyc;
    for (int k = 4; k <= 9; k++) push(c + k, "glitch", 2'b01, 2'b00, 2'b00, 2'b01);
    raw_in[1] = 1'b1;
    wait_n(3);
    raw_in[1] = 1'b0;
    wait_n(7);

    // Held press on channel 1 is accepted
    c = cyc;
    raw_in[1] = 1'b1;
    push(c + 5, "ch1_early", 2'b01, 2'b00, 2'b00, 2'b01);
    push(c + 6, "ch1_acc",   2'b11, 2'b10, 2'b00, 2'b11);
    push(c + 7, "ch1_end",   2'b11, 2'b00, 2'b00, 2'b11);
    wait_n(10);

    // Fall on channel 0 keeps toggle
    c = cyc;
    raw_in[0] = 1'b0;
    push(c + 5, "fall_early", 2'b11, 2'b00, 2'b00, 2'b11);
    push(c + 6, "fall_acc",   2'b10, 2'b00, 2'b01, 2'b11);
    push(c + 7, "fall_end",   2'b10, 2'b00, 2'b00, 2'b11);
    wait_n(10);

    // Bounce 1,0,1,1,0 then steady 1: one pulse, toggle back to 0
    c = cyc;
    s = c + 5;
    for (int k = c + 1; k <= s + 7; k++) begin
      push(k, "bounce",
           (k >= s + 6) ? 2'b11 : 2'b10,
           (k == s + 6) ? 2'b01 : 2'b00,
           2'b00,
           (k >= s + 6) ? 2'b10 : 2'b11);
    end
    raw_in[0] = 1'b1; wait_n(1);
    raw_in[0] = 1'b0; wait_n(1);
    raw_in[0] = 1'b1; wait_n(2);
    raw_in[0] = 1'b0; wait_n(1);
    raw_in[0] = 1'b1;
    wait_n(12);

    // Simultaneous falls
    c = cyc;
    raw_in = 2'b00;
    push(c + 6, "both_fall",     2'b00, 2'b00, 2'b11, 2'b10);
    push(c + 7, "both_fall_end", 2'b00, 2'b00, 2'b00, 2'b10);
    wait_n(10);

    // Reset in the middle of qualification (cnt == 2 after edge c+4)
    raw_in[0] = 1'b1;
    wait_n(4);
    rst_n = 1'b0;
    #1;
    cmp("rst_mid_lvl",  level_out,  '0);
    cmp("rst_mid_rise", rise_pulse, '0);
    cmp("rst_mid_fall", fall_pulse, '0);
    cmp("rst_mid_tog",  toggle_out, '0);
    wait_n(2);
    rst_n = 1'b1;
    r = cyc;
    for (int k = r + 1; k <= r + 7; k++) begin
      push(k, "post_rst",
           (k >= r + 6) ? 2'b01 : 2'b00,
           (k == r + 6) ? 2'b01 : 2'b00,
           2'b00,
           (k >= r + 6) ? 2'b01 : 2'b00);
    end
    wait_n(10);

    // Release channel 0, then press both together
    c = cyc;
    raw_in[0] = 1'b0;
    push(c + 6, "ch0_fall", 2'b00, 2'b00, 2'b01, 2'b01);
    wait_n(10);
    c = cyc;
    raw_in = 2'b11;
    push(c + 6, "both_rise",     2'b11, 2'b11, 2'b00, 2'b10);
    push(c + 7, "both_rise_end", 2'b11, 2'b00, 2'b00, 2'b10);
    wait_n(10);

    // Every expectation must have been consumed
    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
# io_input_conditioner

Input-conditioning stage that sits between the raw switch/button pads on `io_in` and the counter logic in the user-design top level. For each channel it synchronises the asynchronous pad signal, debounces it with a per-channel qualification counter, and produces a clean level, single-cycle rise/fall pulses and an optional toggle. The counter's enable input is taken from this block's outputs, for example the button toggle or the switch level, rather than directly from the pad.

## Interface

Parameters:
- `WIDTH`, default 2: number of independent input channels (e.g. switch, button).
- `DEBOUNCE_CYCLES`, default 50000: consecutive cycles a changed input must hold before it is accepted. Legal range is 1 to 2^24−1.
- `RESET_LEVEL`, default 0 (`WIDTH` bits): reset value of the synchroniser flops and the stable level.

Ports:
- `clk`, input, 1: the only clock; all state is updated on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `raw_in`, input, `WIDTH`: unsynchronised pad inputs, e.g. `io_in[11:10]`.
- `level_out`, output, `WIDTH`: debounced stable level.
- `rise_pulse`, output, `WIDTH`: high for exactly one cycle when `level_out` goes 0→1.
- `fall_pulse`, output, `WIDTH`: high for exactly one cycle when `level_out` goes 1→0.
- `toggle_out`, output, `WIDTH`: flips on each rise. Only meaningful when `IO_COND_TOGGLE_EN` is defined.

## Operation

- Each channel is independent and uses an identical datapath: `sync1`, then `sync2`, then the counter, then `stable`.
- Synchroniser: two flops in series.
  - `sync1 <= raw_in`.
  - `sync2 <= sync1`.
- Qualification counter `cnt`:
  - Width is `$clog2(DEBOUNCE_CYCLES+1)` bits.
  - If `sync2 == stable`: `cnt <= 0`. This is the glitch-reject path.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync2`, `cnt <= 0`, and the matching pulse is set.
  - Otherwise: `cnt <= cnt + 1`.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so it cannot wrap.
- Pulses are registered outputs.
  - `rise_pulse` is set on the edge where `stable` goes 0→1 and cleared on the next edge.
  - `fall_pulse` behaves the same way for a 1→0 change of `stable`.
  - `rise_pulse` and `fall_pulse` are never both high on the same channel.
- Toggle: on the same edge that sets `rise_pulse`, `toggle <= ~toggle`.
- `level_out` is driven by `stable`.
- Reset (`rst_n` low): takes effect immediately, without waiting for a clock edge, including in the middle of a qualification.
  - `sync1`, `sync2` and `stable` load `RESET_LEVEL`.
  - `cnt`, `toggle`, `rise_pulse` and `fall_pulse` clear to 0.
  - No pulse is generated on reset release. This holds even if `raw_in` differs from `RESET_LEVEL`: that difference is qualified normally afterwards.

## Timing

- Let N = `DEBOUNCE_CYCLES`. Edge 1 is the first rising edge that samples a new `raw_in` value.
  - Edge 2: `sync2` takes the new value.
  - Edge N+2: `stable`/`level_out` update and the pulse is asserted.
  - Edge N+3: the pulse deasserts.
- Total latency from pad change to `level_out` is therefore N+2 cycles.
  - With N=1 the update happens at edge 3.
- Any cycle in which `sync2` equals `stable` before the count completes restarts qualification from 0.
- If the input returns to the old level during qualification, no output changes.
- Channels never interact. Simultaneous acceptances on different channels produce simultaneous pulses.
- After reset is released, the first edge at which `level_out` can change is edge N+2.

## Configuration

- Macro: `IO_COND_TOGGLE_EN`.
- Defined: the per-channel toggle flop is instantiated, and `toggle_out` reflects it as described in Operation.
- Not defined: no toggle flops are built and `toggle_out` is tied to constant 0.
- Level and pulse behaviour is identical in both builds.

## Test plan

All scenarios use `WIDTH=2`, `DEBOUNCE_CYCLES=4`, `RESET_LEVEL=0`, with `IO_COND_TOGGLE_EN` defined unless noted.

1. **Clean rise:** raise `raw_in[0]` before edge 1 and hold it high. Expect `level_out[0]` = 1 from edge 6, `rise_pulse[0]` high only between edges 6 and 7, `toggle_out[0]` = 1, and `fall_pulse` at 0 throughout.
2. **Glitch reject:** hold `raw_in[1]` high for 3 cycles, then low. Expect `level_out[1]`, `rise_pulse[1]` and `toggle_out[1]` to stay 0. Then hold it high for 4 cycles or more and expect acceptance at sample+6.
3. **Bounce then settle:** drive `raw_in[0]` with the pattern 1,0,1,1,0 followed by steady 1. Expect exactly one `rise_pulse[0]`, 6 edges after the start of the steady 1.
4. **Fall and toggle:** from an accepted high, drop `raw_in[0]` for 4 cycles or more. Expect `fall_pulse[0]` for one cycle and `level_out[0]` = 0, with `toggle_out[0]` unchanged. A second press flips `toggle_out[0]` back to 0.
5. **Reset mid-qualification:** pulse `rst_n` low asynchronously while `cnt[0]` = 2. Expect every output at 0 immediately. After release, with `raw_in[0]` still high, `level_out[0]` rises 6 edges later with a single pulse.
6. **Simultaneous channels and build option:** assert both channels on the same cycle and expect both `rise_pulse` bits high together. Repeat with `IO_COND_TOGGLE_EN` undefined and expect `toggle_out` = 2'b00 throughout, with pulses unchanged.
